// File: rtl/doce_rx_frame_filter_pkg.sv
// Shared DoCE transport-layer definitions: frame constants, header byte
// layout, receive-filter state encoding and header field extractors.
package doce_rx_frame_filter_pkg;

  // EtherType carried by every DoCE frame.
  localparam logic [15:0] DOCE_ETHERTYPE_C = 16'h88B5;

  // Ethernet broadcast destination address.
  localparam logic [47:0] BCAST_MAC_C = 48'hFFFF_FFFF_FFFF;

  // Byte offsets of the Ethernet header inside the first 128-bit beat.
  localparam int unsigned DST_OFF_C   = 32'd0;
  localparam int unsigned SRC_OFF_C   = 32'd6;
  localparam int unsigned ETYPE_OFF_C = 32'd12;
  localparam int unsigned HDR_LEN_C   = 32'd14;

  // Receive filter states. RESYNC swallows a frame that was already in
  // flight when reset released, so the filter never mistakes a mid-frame
  // beat for a header.
  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_IDLE   = 2'd1,
    ST_PASS   = 2'd2,
    ST_DROP   = 2'd3
  } rx_state_e;

  // Byte idx of a beat; byte 0 is the first byte on the wire.
  function automatic logic [7:0] hdr_byte(input logic [127:0] data,
                                          input int unsigned  idx);
    return data[32'd8 * idx +: 8];
  endfunction

  // Six consecutive bytes starting at off, first byte in the MSBs.
  function automatic logic [47:0] hdr_mac(input logic [127:0] data,
                                          input int unsigned  off);
    logic [47:0] mac;
    mac = 48'h0;
    for (int unsigned i = 32'd0; i < 32'd6; i++) begin
      mac = {mac[39:0], hdr_byte(data, off + i)};
    end
    return mac;
  endfunction

  // EtherType field, network byte order.
  function automatic logic [15:0] hdr_etype(input logic [127:0] data);
    return {hdr_byte(data, ETYPE_OFF_C), hdr_byte(data, ETYPE_OFF_C + 32'd1)};
  endfunction

  // True when every byte of the Ethernet header is present in the beat.
  function automatic logic hdr_keep_ok(input logic [15:0] keep);
    return (keep[HDR_LEN_C-1:0] == 14'h3FFF);
  endfunction

endpackage

// File: rtl/doce_sat_counter.sv
// Saturating event counter with synchronous clear. Clear wins over a
// same-cycle increment; the count sticks at all-ones instead of wrapping.
module doce_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value
);

  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX_C  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;

  // Next count: clear first, then increment unless already saturated.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = ZERO_C;
    end else if (inc && (value_q != MAX_C)) begin
      value_d = value_q + ONE_C;
    end else begin
      value_d = value_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= ZERO_C;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/doce_rx_frame_filter.sv
// DoCE receive frame filter. Inspects the first beat of every frame from
// the MAC, forwards frames addressed to this node (or broadcast) with the
// DoCE EtherType through a one-deep output register, silently consumes
// everything else, and counts accepted/dropped frames.
module doce_rx_frame_filter
  import doce_rx_frame_filter_pkg::*;
#(
  parameter logic [15:0] DOCE_ETHERTYPE = DOCE_ETHERTYPE_C,
  parameter bit          ACCEPT_BCAST   = 1'b1,
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [47:0]      doce_mac_addr,
  input  logic [127:0]     s_axis_tdata,
  input  logic [15:0]      s_axis_tkeep,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [127:0]     m_axis_tdata,
  output logic [15:0]      m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  input  logic             stat_clear,
  output logic [CNT_W-1:0] stat_accept_cnt,
  output logic [CNT_W-1:0] stat_drop_cnt
);

  rx_state_e      state_q;
  rx_state_e      state_d;

  logic [127:0]   m_tdata_q;
  logic [127:0]   m_tdata_d;
  logic [15:0]    m_tkeep_q;
  logic [15:0]    m_tkeep_d;
  logic           m_tlast_q;
  logic           m_tlast_d;
  logic           m_tvalid_q;
  logic           m_tvalid_d;

  logic           out_ready_s;
  logic           s_tready_s;
  logic           s_xfer_s;
  logic [47:0]    dst_s;
  logic [15:0]    etype_s;
  logic           dst_ok_s;
  logic           hdr_ok_s;
  logic           load_s;
  logic           acc_inc_s;
  logic           drop_inc_s;

  // The output slot can take a beat when empty or draining this cycle.
  assign out_ready_s = !m_tvalid_q || m_axis_tready;

  // Header fields of the current beat; only meaningful in IDLE.
  assign dst_s    = hdr_mac(s_axis_tdata, DST_OFF_C);
  assign etype_s  = hdr_etype(s_axis_tdata);
  assign dst_ok_s = (dst_s == doce_mac_addr) ||
                    (ACCEPT_BCAST && (dst_s == BCAST_MAC_C));
  assign hdr_ok_s = hdr_keep_ok(s_axis_tkeep) &&
                    (etype_s == DOCE_ETHERTYPE) && dst_ok_s;

  // Input ready: discarding states never stall, forwarding-capable states
  // follow the output slot.
  always_comb begin
    s_tready_s = 1'b1;
    case (state_q)
      ST_RESYNC: s_tready_s = 1'b1;
      ST_IDLE:   s_tready_s = out_ready_s;
      ST_PASS:   s_tready_s = out_ready_s;
      ST_DROP:   s_tready_s = 1'b1;
      default:   s_tready_s = 1'b1;
    endcase
  end

  assign s_xfer_s      = s_axis_tvalid && s_tready_s;
  assign s_axis_tready = s_tready_s;

  // Frame FSM: classify the first beat, then forward or discard to tlast.
  always_comb begin
    state_d    = state_q;
    load_s     = 1'b0;
    acc_inc_s  = 1'b0;
    drop_inc_s = 1'b0;
    case (state_q)
      ST_RESYNC: begin
        if (s_xfer_s && s_axis_tlast) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESYNC;
        end
      end
      ST_IDLE: begin
        if (s_xfer_s) begin
          if (hdr_ok_s) begin
            load_s    = 1'b1;
            acc_inc_s = 1'b1;
            state_d   = s_axis_tlast ? ST_IDLE : ST_PASS;
          end else begin
            drop_inc_s = 1'b1;
            state_d    = s_axis_tlast ? ST_IDLE : ST_DROP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PASS: begin
        if (s_xfer_s) begin
          load_s  = 1'b1;
          state_d = s_axis_tlast ? ST_IDLE : ST_PASS;
        end else begin
          state_d = ST_PASS;
        end
      end
      ST_DROP: begin
        if (s_xfer_s && s_axis_tlast) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_RESYNC;
      end
    endcase
  end

  // FSM state register; reset lands in RESYNC because the MAC may be
  // mid-frame when reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RESYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Output slot next value: load on a forwarded beat, empty on a drain,
  // otherwise hold so the downstream sees a stable beat while stalled.
  always_comb begin
    m_tdata_d  = m_tdata_q;
    m_tkeep_d  = m_tkeep_q;
    m_tlast_d  = m_tlast_q;
    m_tvalid_d = m_tvalid_q;
    if (load_s) begin
      m_tdata_d  = s_axis_tdata;
      m_tkeep_d  = s_axis_tkeep;
      m_tlast_d  = s_axis_tlast;
      m_tvalid_d = 1'b1;
    end else if (m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end else begin
      m_tvalid_d = m_tvalid_q;
    end
  end

  // Output slot register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_tdata_q  <= 128'h0;
      m_tkeep_q  <= 16'h0;
      m_tlast_q  <= 1'b0;
      m_tvalid_q <= 1'b0;
    end else begin
      m_tdata_q  <= m_tdata_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tlast_q  <= m_tlast_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tkeep  = m_tkeep_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tvalid = m_tvalid_q;

  doce_sat_counter #(.CNT_W(CNT_W)) u_accept_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (acc_inc_s),
    .clr   (stat_clear),
    .value (stat_accept_cnt)
  );

  doce_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (drop_inc_s),
    .clr   (stat_clear),
    .value (stat_drop_cnt)
  );

endmodule
